// File: rtl/unpool_layer_pkg.sv
// Shared definitions for the pooling / unpooling layers: FSM encoding,
// mode constants and default map dimensions.
package unpool_layer_pkg;

    // Two-state expansion controller
    typedef enum logic {
        StIdle   = 1'b0,
        StExpand = 1'b1
    } unpool_state_t;

    // Pixel scaling modes
    localparam logic MODE_REPLICATE = 1'b0;
    localparam logic MODE_AVG_BWD   = 1'b1;

    // Backward average over a 2x2 window spreads the gradient by 1/4
    localparam int unsigned AVG_BWD_SHIFT = 2;

    // Default dimensions
    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned DEFAULT_IN_W   = 3;
    localparam int unsigned DEFAULT_OUT_W  = 6;

    // Index width that never collapses to zero bits for tiny maps
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/unpool_scale_unit.sv
// Per-pixel scaling: pass-through for replicate mode, arithmetic divide-by-4
// (floor, sign preserved) for average-pool backward mode.
module unpool_scale_unit
    import unpool_layer_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic                     mode,
    input  logic signed [DATA_W-1:0] pixel_in,
    output logic signed [DATA_W-1:0] pixel_out
);

    // Select scaled or raw pixel
    always_comb begin
        pixel_out = pixel_in;
        if (mode == MODE_AVG_BWD) begin
            pixel_out = pixel_in >>> AVG_BWD_SHIFT;
        end
    end

endmodule

// File: rtl/unpool_layer.sv
// 2x unpooling layer: snapshots an IN_W x IN_W map on start, then writes one
// output pixel per cycle into a registered OUT_W x OUT_W map, row-major.
module unpool_layer
    import unpool_layer_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned IN_W   = DEFAULT_IN_W,
    parameter int unsigned OUT_W  = DEFAULT_OUT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     mode,
    input  logic signed [DATA_W-1:0] input_fm  [0:IN_W*IN_W-1],
    output logic                     busy,
    output logic                     done,
    output logic signed [DATA_W-1:0] output_fm [0:OUT_W*OUT_W-1]
);

    localparam int unsigned IN_PIX  = IN_W * IN_W;
    localparam int unsigned OUT_PIX = OUT_W * OUT_W;
    localparam int unsigned CNT_W   = idx_width(OUT_W);
    localparam int unsigned SRC_W   = idx_width(IN_PIX);
    localparam int unsigned DST_W   = idx_width(OUT_PIX);

    localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(OUT_W - 1);

    unpool_state_t           state_q;
    logic [CNT_W-1:0]        row_q;
    logic [CNT_W-1:0]        col_q;
    logic                    mode_q;
    logic                    busy_q;
    logic                    done_q;
    logic signed [DATA_W-1:0] snap_q [0:IN_PIX-1];
    logic signed [DATA_W-1:0] out_q  [0:OUT_PIX-1];

    logic [SRC_W-1:0]         src_idx;
    logic [DST_W-1:0]         dst_idx;
    logic                     last_pix;
    logic signed [DATA_W-1:0] scaled;

    // Source word and destination slot for the current (row, col)
    always_comb begin
        src_idx  = SRC_W'((32'(row_q) >> 1) * IN_W + (32'(col_q) >> 1));
        dst_idx  = DST_W'(32'(row_q) * OUT_W + 32'(col_q));
        last_pix = (row_q == LAST_POS) && (col_q == LAST_POS);
    end

    unpool_scale_unit #(
        .DATA_W(DATA_W)
    ) u_scale (
        .mode     (mode_q),
        .pixel_in (snap_q[src_idx]),
        .pixel_out(scaled)
    );

    // Controller, snapshot buffer and output map
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            row_q   <= '0;
            col_q   <= '0;
            mode_q  <= MODE_REPLICATE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int unsigned i = 0; i < IN_PIX; i++) begin
                snap_q[i] <= '0;
            end
            for (int unsigned i = 0; i < OUT_PIX; i++) begin
                out_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        for (int unsigned i = 0; i < IN_PIX; i++) begin
                            snap_q[i] <= input_fm[i];
                        end
                        mode_q  <= mode;
                        row_q   <= '0;
                        col_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state_q <= StExpand;
                    end
                end
                StExpand: begin
                    out_q[dst_idx] <= scaled;
                    if (last_pix) begin
                        row_q   <= '0;
                        col_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end else if (col_q == LAST_POS) begin
                        col_q <= '0;
                        row_q <= row_q + 1'b1;
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign output_fm = out_q;

endmodule

// File: tb/tb_unpool_layer.sv
// Self-checking bench for unpool_layer with a behavioural expansion model.
module tb_unpool_layer;

    localparam int DW      = 32;
    localparam int IW      = 3;
    localparam int OW      = 6;
    localparam int NIN     = IW * IW;
    localparam int NOUT    = OW * OW;
    localparam int TIMEOUT = 100;

    typedef logic signed [DW-1:0] pix_t;
    typedef pix_t map_in_t  [0:NIN-1];
    typedef pix_t map_out_t [0:NOUT-1];

    logic     clk = 1'b0;
    logic     rst;
    logic     start;
    logic     mode;
    map_in_t  in_fm;
    logic     busy;
    logic     done;
    map_out_t out_fm;

    int       total = 0;
    int       bad   = 0;
    map_out_t exp_map;
    map_out_t prev_map;

    always #5 clk = ~clk;

    unpool_layer #(
        .DATA_W(DW),
        .IN_W  (IW),
        .OUT_W (OW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .input_fm (in_fm),
        .busy     (busy),
        .done     (done),
        .output_fm(out_fm)
    );

    // Each 2x2 output block takes its parent pixel; mode 1 divides by 4, floored
    task automatic build_model(input map_in_t src, input logic m);
        for (int r = 0; r < OW; r++) begin
            for (int c = 0; c < OW; c++) begin
                longint v = longint'(src[(r / 2) * IW + (c / 2)]);
                longint q = v;
                if (m) begin
                    q = v / 4;
                    if (v < 0 && (v % 4) != 0) q = q - 1;
                end
                exp_map[r * OW + c] = DW'(q);
            end
        end
    endtask

    task automatic rand_map(output map_in_t src);
        for (int k = 0; k < NIN; k++) begin
            if ($urandom_range(0, 1) == 1) src[k] = DW'($urandom);
            else src[k] = DW'(int'($urandom_range(0, 40)) - 20);
        end
    endtask

    // Present start for one edge; returns at the negedge just after that edge
    task automatic launch(input map_in_t src, input logic m);
        @(negedge clk);
        in_fm = src;
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts busy samples from the current negedge until done is seen
    task automatic wait_done(output int at, output int bcnt);
        at   = -1;
        bcnt = (busy === 1'b1) ? 1 : 0;
        for (int i = 1; i <= TIMEOUT; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                at = i;
                break;
            end
            if (busy === 1'b1) bcnt++;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        for (int k = 0; k < NIN; k++) in_fm[k] = '0;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        for (int i = 0; i < NOUT; i++) begin
            total++;
            if (out_fm[i] !== '0) begin
                bad++;
                $display("FAIL reset_map[%0d]: got %0d want 0", i, out_fm[i]);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < NOUT; i++) exp_map[i] = '0;
    endtask

    task automatic test_replicate();
        map_in_t src;
        int      at, bc;
        int      idx [12] = '{0, 1, 6, 7, 4, 5, 10, 11, 28, 29, 34, 35};
        int      val [12] = '{1, 1, 1, 1, 3, 3, 3, 3, 9, 9, 9, 9};
        for (int k = 0; k < NIN; k++) src[k] = DW'(k + 1);
        launch(src, 1'b0);
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL rep_start_flags: got busy=%b done=%b want busy=1 done=0", busy, done);
        end
        wait_done(at, bc);
        total++;
        if (at !== 36) begin bad++; $display("FAIL rep_latency: got %0d want 36", at); end
        total++;
        if (bc !== 36) begin bad++; $display("FAIL rep_busy_cycles: got %0d want 36", bc); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL rep_busy_end: got %b want 0", busy); end
        for (int j = 0; j < 12; j++) begin
            total++;
            if (out_fm[idx[j]] !== DW'(val[j])) begin
                bad++;
                $display("FAIL rep_pix[%0d]: got %0d want %0d", idx[j], out_fm[idx[j]], val[j]);
            end
        end
        build_model(src, 1'b0);
        for (int i = 0; i < NOUT; i++) begin
            total++;
            if (out_fm[i] !== exp_map[i]) begin
                bad++;
                $display("FAIL rep_map[%0d]: got %0d want %0d", i, out_fm[i], exp_map[i]);
            end
        end
        // Idle with start low must hold everything
        for (int k = 0; k < NIN; k++) in_fm[k] = DW'(-100);
        repeat (5) @(negedge clk);
        total++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_hold_flags: got busy=%b done=%b want busy=0 done=1", busy, done);
        end
        for (int i = 0; i < NOUT; i++) begin
            total++;
            if (out_fm[i] !== exp_map[i]) begin
                bad++;
                $display("FAIL idle_hold_map[%0d]: got %0d want %0d", i, out_fm[i], exp_map[i]);
            end
        end
    endtask

    task automatic test_avg_bwd();
        map_in_t src;
        int      at, bc;
        pix_t    want;
        for (int k = 0; k < NIN; k++) src[k] = '0;
        src[0] = DW'(8);
        src[4] = DW'(-5);
        launch(src, 1'b1);
        wait_done(at, bc);
        total++;
        if (at !== 36) begin bad++; $display("FAIL avg_latency: got %0d want 36", at); end
        for (int i = 0; i < NOUT; i++) begin
            want = '0;
            if (i == 0 || i == 1 || i == 6 || i == 7) want = DW'(2);
            if (i == 14 || i == 15 || i == 20 || i == 21) want = DW'(-2);
            total++;
            if (out_fm[i] !== want) begin
                bad++;
                $display("FAIL avg_map[%0d]: got %0d want %0d", i, out_fm[i], want);
            end
        end
        build_model(src, 1'b1);
    endtask

    task automatic test_random();
        map_in_t src;
        logic    m;
        int      at, bc;
        for (int it = 0; it < 6; it++) begin
            rand_map(src);
            m        = 1'($urandom_range(0, 1));
            prev_map = exp_map;
            build_model(src, m);
            launch(src, m);
            repeat (10) @(negedge clk);
            // Indices 0..9 rewritten so far; later slots keep the old map
            total++;
            if (out_fm[20] !== prev_map[20]) begin
                bad++;
                $display("FAIL rand_retain[20]: got %0d want %0d", out_fm[20], prev_map[20]);
            end
            total++;
            if (out_fm[5] !== exp_map[5]) begin
                bad++;
                $display("FAIL rand_partial[5]: got %0d want %0d", out_fm[5], exp_map[5]);
            end
            wait_done(at, bc);
            total++;
            if (at + 10 !== 36) begin
                bad++;
                $display("FAIL rand_latency: got %0d want 36", at + 10);
            end
            for (int i = 0; i < NOUT; i++) begin
                total++;
                if (out_fm[i] !== exp_map[i]) begin
                    bad++;
                    $display("FAIL rand_map[%0d]: got %0d want %0d", i, out_fm[i], exp_map[i]);
                end
            end
        end
    endtask

    task automatic test_ignore_mid_run();
        map_in_t src;
        int      at, bc;
        rand_map(src);
        build_model(src, 1'b0);
        launch(src, 1'b0);
        repeat (9) @(negedge clk);
        for (int k = 0; k < NIN; k++) in_fm[k] = DW'(7);
        mode  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(at, bc);
        total++;
        if (at + 10 !== 36) begin bad++; $display("FAIL ign_latency: got %0d want 36", at + 10); end
        for (int i = 0; i < NOUT; i++) begin
            total++;
            if (out_fm[i] !== exp_map[i]) begin
                bad++;
                $display("FAIL ign_map[%0d]: got %0d want %0d", i, out_fm[i], exp_map[i]);
            end
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            bad++;
            $display("FAIL ign_no_restart: got busy=%b done=%b want busy=0 done=1", busy, done);
        end
    endtask

    task automatic test_reset_mid_run();
        map_in_t src;
        int      at, bc;
        rand_map(src);
        launch(src, 1'b1);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_flags: got busy=%b done=%b want busy=0 done=0", busy, done);
        end
        for (int i = 0; i < NOUT; i++) begin
            total++;
            if (out_fm[i] !== '0) begin
                bad++;
                $display("FAIL rstmid_map[%0d]: got %0d want 0", i, out_fm[i]);
            end
        end
        rand_map(src);
        build_model(src, 1'b0);
        launch(src, 1'b0);
        wait_done(at, bc);
        total++;
        if (at !== 36) begin bad++; $display("FAIL rstmid_latency: got %0d want 36", at); end
        for (int i = 0; i < NOUT; i++) begin
            total++;
            if (out_fm[i] !== exp_map[i]) begin
                bad++;
                $display("FAIL rstmid_rerun[%0d]: got %0d want %0d", i, out_fm[i], exp_map[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        map_in_t a, b;
        logic    ma, mb;
        int      at, bc;
        rand_map(a);
        rand_map(b);
        ma = 1'b0;
        mb = 1'b1;
        @(negedge clk);
        in_fm = a;
        mode  = ma;
        start = 1'b1;
        @(negedge clk);
        wait_done(at, bc);
        total++;
        if (at !== 36) begin bad++; $display("FAIL b2b_latency1: got %0d want 36", at); end
        total++;
        if (bc !== 36) begin bad++; $display("FAIL b2b_busy1: got %0d want 36", bc); end
        build_model(a, ma);
        for (int i = 0; i < NOUT; i++) begin
            total++;
            if (out_fm[i] !== exp_map[i]) begin
                bad++;
                $display("FAIL b2b_map1[%0d]: got %0d want %0d", i, out_fm[i], exp_map[i]);
            end
        end
        in_fm = b;
        mode  = mb;
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_restart: got busy=%b done=%b want busy=1 done=0", busy, done);
        end
        wait_done(at, bc);
        start = 1'b0;
        total++;
        if (at !== 36) begin bad++; $display("FAIL b2b_latency2: got %0d want 36", at); end
        total++;
        if (bc !== 36) begin bad++; $display("FAIL b2b_busy2: got %0d want 36", bc); end
        build_model(b, mb);
        for (int i = 0; i < NOUT; i++) begin
            total++;
            if (out_fm[i] !== exp_map[i]) begin
                bad++;
                $display("FAIL b2b_map2[%0d]: got %0d want %0d", i, out_fm[i], exp_map[i]);
            end
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL b2b_stop: got busy=%b want 0", busy); end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        for (int k = 0; k < NIN; k++) in_fm[k] = '0;
        test_reset();
        test_replicate();
        test_avg_bwd();
        test_random();
        test_ignore_mid_run();
        test_reset_mid_run();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/unpool_layer.md
UNPOOL_LAYER -- requirements
Module: unpool_layer

Interface
REQ-001 Parameter DATA_W, default 32, signed pixel width.
REQ-002 Parameter IN_W, default 3, input feature-map width and height (square map).
REQ-003 Parameter OUT_W, default 6, output feature-map width and height; SHALL equal 2*IN_W.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request to expand one map; sampled only in IDLE.
REQ-007 mode  input  1  0 = nearest-neighbour replicate, 1 = average-pool backward (divide by 4); sampled with start.
REQ-008 input_fm  input  signed DATA_W x IN_W*IN_W array [0:8]  row-major input map.
REQ-009 busy  output  1  high while expanding.
REQ-010 done  output  1  high from completion until the next accepted start.
REQ-011 output_fm  output  signed DATA_W x OUT_W*OUT_W array [0:35]  row-major registered output map.

Function
REQ-012 The FSM SHALL have two states: IDLE and EXPAND.
REQ-013 On an edge in IDLE with start=1, the block SHALL snapshot all 9 input_fm words and mode into internal registers, clear done, set busy, zero the output index and enter EXPAND.
REQ-014 In IDLE with start=0, all outputs SHALL hold their values.
REQ-015 Each EXPAND edge SHALL write exactly one output pixel output_fm[r*OUT_W+c], with r,c advancing column-first (c 0..5, then r+1).
REQ-016 Pixel value SHALL be buf[(r>>1)*IN_W+(c>>1)] for mode 0; for mode 1, the same word arithmetically shifted right by 2 (rounds toward negative infinity, sign preserved, no saturation).
REQ-017 The write of index 35 SHALL return the FSM to IDLE, clear busy and set done on the same edge.
REQ-018 Latency: start sampled at edge N; writes at edges N+1..N+36; done=1 and busy=0 visible after edge N+36.
REQ-019 start, mode and input_fm changes during EXPAND SHALL be ignored; only the snapshot is used.
REQ-020 Output pixels not yet rewritten during EXPAND SHALL retain their previous values.
REQ-021 start held high continuously SHALL cause a new run to begin on the edge after done rises; done SHALL fall on that edge.

Reset
REQ-022 rst=1 SHALL dominate all other inputs on any edge, including mid-EXPAND.
REQ-023 Reset values: state IDLE, busy 0, done 0, every output_fm word 0, index counters 0, snapshot buffer 0.
REQ-024 After rst deasserts, the first edge with start=1 SHALL begin a normal run.

Structure
REQ-025 A shared package SHALL hold the FSM state encoding, the mode constants (MODE_REPLICATE=0, MODE_AVG_BWD=1) and default dimension constants, for reuse with the pooling layer.
REQ-026 The per-pixel scale (mode select plus arithmetic shift) SHALL be one combinational sub-module, unpool_scale_unit; index and address generation stay in unpool_layer.

Verification
REQ-027 Mode 0, input_fm = 1..9, start one cycle -> output_fm[0,1,6,7]=1, output_fm[4,5,10,11]=3, output_fm[28,29,34,35]=9; done rises exactly 36 edges after the start edge.
REQ-028 Mode 1, input_fm[0]=8, input_fm[4]=-5, others 0 -> output_fm[0,1,6,7]=2, output_fm[14,15,20,21]=-2, all others 0.
REQ-029 Change input_fm to all 7 and pulse start at edge N+10 of a run -> final map matches the original snapshot; no restart; done still at N+36.
REQ-030 Assert rst at edge N+10 of a run -> busy=0, done=0, all output_fm=0 on the next cycle; a following start completes a correct run.
REQ-031 Hold start high across two runs with different input_fm -> done pulses high for one cycle between runs, second map correct, busy high 36 cycles each run.
